// File: rtl/mdio_master_if.sv
// MDIO master request/response bus.
//
// Carries one PHY register transaction per valid/ready handshake from the
// configuration sequencer to the MDIO master, and the single-cycle response
// back. The MDIO pad signals are not part of this bus.
//
//   req_valid/req_ready  handshake; accept = req_valid & req_ready
//   req_c45              1: Clause 45 frame, 0: Clause 22 frame
//   req_op               OP field, sent verbatim
//   req_phyad            PHY / port address
//   req_regad            register address (C22) or DEVAD (C45)
//   req_wdata            write data, or register address for a C45 addr frame
//   rsp_valid            1-cycle pulse at transaction end
//   rsp_rdata            read data, held until the next rsp_valid
//   rsp_ta_err           read turnaround error, valid with rsp_valid
//   busy                 transaction in progress
//
// modport master: the requesting side (sequencer)
// modport slave : the MDIO master controller
interface mdio_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_c45;
    logic [1:0]  req_op;
    logic [4:0]  req_phyad;
    logic [4:0]  req_regad;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_ta_err;
    logic        busy;

    modport master (
        output req_valid, req_c45, req_op, req_phyad, req_regad, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_ta_err, busy
    );

    modport slave (
        input  req_valid, req_c45, req_op, req_phyad, req_regad, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_ta_err, busy
    );
endinterface

// File: rtl/mdio_master_ctrl.sv
// MDIO station-management master (Clause 22 / optional Clause 45).
//
// Runs on the system clock and derives MDC internally. One transaction is
// accepted per handshake on the request bus; the frame is preamble (PRE_LEN
// ones), then 32 bits {ST,OP,PHYAD,REGAD,TA,DATA} MSB first, then one idle
// slot with the pad released. A response pulse ends every transaction.
//
// Ports
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   bus      mdio_master_if.slave request/response bus
//   mdc      management clock to the pad, low when idle
//   mdio_o   MDIO output value to the pad
//   mdio_oe  MDIO output enable (1 = drive)
//   mdio_i   MDIO input from the pad (pulled up)
//
// Parameters
//   CLK_DIV      system clocks per MDC half-period (>= 2)
//   PRE_LEN      preamble length in bits, 0..32
//   SUPPORT_C45  0 forces every frame to Clause 22 (ST=01)
module mdio_master_ctrl #(
    parameter int CLK_DIV     = 10,
    parameter int PRE_LEN     = 32,
    parameter bit SUPPORT_C45 = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    mdio_master_if.slave bus,
    output logic         mdc,
    output logic         mdio_o,
    output logic         mdio_oe,
    input  logic         mdio_i
);
    localparam int             HW       = $clog2(CLK_DIV);
    localparam logic [HW-1:0]  HC_LAST  = HW'(CLK_DIV - 1);
    localparam logic [5:0]     PRE_LAST = (PRE_LEN > 0) ? 6'(PRE_LEN - 1) : 6'd0;

    typedef enum logic [1:0] {IDLE, PRE, FRAME, DONE} state_t;

    state_t        state;
    logic [HW-1:0] hcnt;
    logic [5:0]    bitcnt;
    logic [31:0]   sreg;
    logic [15:0]   rd_sh;
    logic          is_rd;
    logic          ta_err;
    logic [1:0]    st_field;
    logic [31:0]   frame_word;

    always_comb begin
        st_field   = (SUPPORT_C45 && bus.req_c45) ? 2'b00 : 2'b01;
        frame_word = {st_field, bus.req_op, bus.req_phyad, bus.req_regad, 2'b10, bus.req_wdata};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            hcnt           <= '0;
            bitcnt         <= '0;
            sreg           <= '0;
            rd_sh          <= '0;
            is_rd          <= 1'b0;
            ta_err         <= 1'b0;
            mdc            <= 1'b0;
            mdio_o         <= 1'b1;
            mdio_oe        <= 1'b0;
            bus.req_ready  <= 1'b1;
            bus.busy       <= 1'b0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_rdata  <= '0;
            bus.rsp_ta_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mdc     <= 1'b0;
                    mdio_o  <= 1'b1;
                    mdio_oe <= 1'b0;
                    hcnt    <= '0;
                    bitcnt  <= '0;
                    if (bus.rsp_valid) begin
                        // Response cycle: ready reopens only one cycle later.
                        bus.rsp_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                        bus.req_ready <= 1'b1;
                    end else if (bus.req_valid && bus.req_ready) begin
                        bus.req_ready <= 1'b0;
                        bus.busy      <= 1'b1;
                        is_rd         <= bus.req_op[1];
                        ta_err        <= 1'b0;
                        sreg          <= frame_word;
                        mdio_oe       <= 1'b1;
                        if (PRE_LEN == 0) begin
                            state  <= FRAME;
                            mdio_o <= frame_word[31];
                        end else begin
                            state  <= PRE;
                            mdio_o <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (hcnt != HC_LAST) begin
                        hcnt <= hcnt + 1'b1;
                    end else begin
                        hcnt <= '0;
                        mdc  <= ~mdc;
                        // End of the high half: slot boundary, MDC falls next.
                        if (mdc) begin
                            case (state)
                                PRE: begin
                                    if (bitcnt == PRE_LAST) begin
                                        state   <= FRAME;
                                        bitcnt  <= '0;
                                        mdio_o  <= sreg[31];
                                        mdio_oe <= 1'b1;
                                    end else begin
                                        bitcnt <= bitcnt + 1'b1;
                                    end
                                end
                                FRAME: begin
                                    // Slot 15 is the second TA bit, 16..31 carry data.
                                    if (is_rd && bitcnt == 6'd15)
                                        ta_err <= mdio_i;
                                    if (is_rd && bitcnt >= 6'd16)
                                        rd_sh <= {rd_sh[14:0], mdio_i};
                                    if (bitcnt == 6'd31) begin
                                        state   <= DONE;
                                        mdio_o  <= 1'b1;
                                        mdio_oe <= 1'b0;
                                    end else begin
                                        bitcnt  <= bitcnt + 1'b1;
                                        sreg    <= {sreg[30:0], 1'b0};
                                        mdio_o  <= sreg[30];
                                        // Reads release the pad from the first TA slot (14).
                                        mdio_oe <= !(is_rd && bitcnt >= 6'd13);
                                    end
                                end
                                default: begin
                                    state          <= IDLE;
                                    bus.rsp_valid  <= 1'b1;
                                    bus.rsp_rdata  <= is_rd ? rd_sh : 16'h0000;
                                    bus.rsp_ta_err <= is_rd & ta_err;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mdio_master_ctrl.sv
module tb_mdio_master_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    // sel chooses the DUT under test: 0 = default parameters, 1 = CLK_DIV=2, PRE_LEN=0, no C45
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_c45 = 1'b0;
    logic [1:0]  req_op = 2'b00;
    logic [4:0]  req_phyad = 5'd0;
    logic [4:0]  req_regad = 5'd0;
    logic [15:0] req_wdata = 16'd0;

    mdio_master_if bus0();
    mdio_master_if bus1();

    assign bus0.req_valid = req_valid & ~sel;
    assign bus0.req_c45   = req_c45;
    assign bus0.req_op    = req_op;
    assign bus0.req_phyad = req_phyad;
    assign bus0.req_regad = req_regad;
    assign bus0.req_wdata = req_wdata;
    assign bus1.req_valid = req_valid & sel;
    assign bus1.req_c45   = req_c45;
    assign bus1.req_op    = req_op;
    assign bus1.req_phyad = req_phyad;
    assign bus1.req_regad = req_regad;
    assign bus1.req_wdata = req_wdata;

    logic mdc0, o0, oe0, mdc1, o1, oe1;
    logic phy_i = 1'b1;

    mdio_master_ctrl #(.CLK_DIV(10), .PRE_LEN(32), .SUPPORT_C45(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0),
        .mdc(mdc0), .mdio_o(o0), .mdio_oe(oe0), .mdio_i(phy_i)
    );
    mdio_master_ctrl #(.CLK_DIV(2), .PRE_LEN(0), .SUPPORT_C45(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1),
        .mdc(mdc1), .mdio_o(o1), .mdio_oe(oe1), .mdio_i(phy_i)
    );

    logic        m_ready, m_rvld, m_taerr, m_busy, m_mdc, m_o, m_oe;
    logic [15:0] m_rdata;
    assign m_ready = sel ? bus1.req_ready  : bus0.req_ready;
    assign m_rvld  = sel ? bus1.rsp_valid  : bus0.rsp_valid;
    assign m_rdata = sel ? bus1.rsp_rdata  : bus0.rsp_rdata;
    assign m_taerr = sel ? bus1.rsp_ta_err : bus0.rsp_ta_err;
    assign m_busy  = sel ? bus1.busy       : bus0.busy;
    assign m_mdc   = sel ? mdc1 : mdc0;
    assign m_o     = sel ? o1   : o0;
    assign m_oe    = sel ? oe1  : oe0;

    // Wire log: one entry per MDC rising edge (= one bit slot). The PHY model
    // drives the bit planned for the slot whose high half just started.
    logic obs_o[$];
    logic obs_oe[$];
    logic phy_vec[0:4095];

    always @(posedge m_mdc) begin
        phy_i <= phy_vec[obs_o.size()];
        obs_o.push_back(m_o);
        obs_oe.push_back(m_oe);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One transaction on the selected DUT, checked against the frame rules.
    task automatic run_txn(input logic c45, input logic [1:0] op, input logic [4:0] phy,
                           input logic [4:0] rega, input logic [15:0] wdata,
                           input logic [15:0] phy_data, input logic ta2,
                           input logic present, input string tag);
        int base, pre, div, acc, lat, t, bad, nslot;
        logic rd;
        logic c45_ok;
        logic [1:0]  st;
        logic [31:0] ew, eoe, ow, ooe;
        logic [15:0] erd;
        logic        eta;
        pre    = sel ? 0 : 32;
        div    = sel ? 2 : 10;
        c45_ok = !sel;
        rd     = op[1];
        st     = (c45 && c45_ok) ? 2'b00 : 2'b01;
        ew     = {st, op, phy, rega, 2'b10, wdata};
        for (int k = 0; k < 32; k++) eoe[31-k] = !(rd && k >= 14);
        erd = rd ? (present ? phy_data : 16'hFFFF) : 16'h0000;
        eta = rd && (present ? ta2 : 1'b1);

        base = obs_o.size();
        for (int k = 0; k < pre + 33; k++) phy_vec[base+k] = 1'b1;
        if (rd && present) begin
            phy_vec[base+pre+15] = ta2;
            for (int i = 0; i < 16; i++) phy_vec[base+pre+16+i] = phy_data[15-i];
        end

        @(negedge clk);
        req_c45 = c45; req_op = op; req_phyad = phy; req_regad = rega; req_wdata = wdata;
        req_valid = 1'b1;
        check_eq({tag, " ready"}, {31'd0, m_ready}, 32'd1);
        acc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        bad = 0; t = 0;
        while (!m_rvld && t < 5000) begin
            if (!m_busy || m_ready) bad++;
            @(negedge clk);
            t++;
        end
        lat = cyc - acc;
        check_eq({tag, " latency"}, lat, 1 + (pre + 33) * 2 * div);
        check_eq({tag, " busy_hs"}, bad, 0);
        check_eq({tag, " rdata"}, {16'd0, m_rdata}, {16'd0, erd});
        check_eq({tag, " ta_err"}, {31'd0, m_taerr}, {31'd0, eta});
        @(negedge clk);
        check_eq({tag, " post_rsp"}, {29'd0, m_rvld, m_busy, m_ready}, 32'b001);

        nslot = obs_o.size() - base;
        check_eq({tag, " slots"}, nslot, pre + 33);
        if (nslot >= pre + 33) begin
            if (pre > 0) begin
                bad = 0;
                for (int k = 0; k < pre; k++)
                    if (obs_o[base+k] !== 1'b1 || obs_oe[base+k] !== 1'b1) bad++;
                check_eq({tag, " preamble"}, bad, 0);
            end
            for (int k = 0; k < 32; k++) begin
                ow[31-k]  = obs_o[base+pre+k];
                ooe[31-k] = obs_oe[base+pre+k];
            end
            check_eq({tag, " oe"}, ooe, eoe);
            check_eq({tag, " bits"}, ow & eoe, ew & eoe);
            check_eq({tag, " done_oe"}, {31'd0, obs_oe[base+pre+32]}, 32'd0);
        end
    endtask

    task automatic back_to_back();
        int acc_c[4];
        int rsp_c[4];
        int n_acc, n_rsp, bad, t, extra;
        sel = 1'b0;
        @(negedge clk);
        req_c45 = 1'b0; req_op = 2'b01; req_phyad = 5'd7; req_regad = 5'd9; req_wdata = 16'h5AA5;
        req_valid = 1'b1;
        n_acc = 0; n_rsp = 0; bad = 0; t = 0;
        while (n_rsp < 3 && t < 6000) begin
            if (m_ready && req_valid && n_acc < 4) begin acc_c[n_acc] = cyc; n_acc++; end
            if (m_busy && m_ready) bad++;
            if (m_rvld) begin
                rsp_c[n_rsp] = cyc;
                n_rsp++;
                if (n_rsp == 3) req_valid = 1'b0;
            end
            if (n_rsp < 3) begin @(negedge clk); t++; end
        end
        extra = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (m_rvld || m_busy) extra++;
        end
        check_eq("b2b accepts", n_acc, 3);
        check_eq("b2b responses", n_rsp, 3);
        check_eq("b2b ready_busy", bad, 0);
        check_eq("b2b extra", extra, 0);
        for (int i = 0; i < 3; i++)
            if (i < n_acc && i < n_rsp) check_eq("b2b latency", rsp_c[i] - acc_c[i], 1301);
        for (int i = 0; i < 2; i++)
            if (i + 1 < n_acc && i < n_rsp) check_eq("b2b next_accept", acc_c[i+1] - rsp_c[i], 1);
    endtask

    task automatic reset_mid_frame();
        int base, t, pulses;
        sel = 1'b0;
        base = obs_o.size();
        @(negedge clk);
        req_c45 = 1'b0; req_op = 2'b01; req_phyad = 5'd1; req_regad = 5'd4; req_wdata = 16'hBEEF;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        t = 0;
        // wait until the high half of data slot 8 (frame slot 24 after the preamble)
        while (obs_o.size() < base + 32 + 25 && t < 3000) begin @(negedge clk); t++; end
        check_eq("rst reached_slot", {31'd0, t < 3000}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst outputs", {27'd0, m_mdc, m_oe, m_busy, m_ready, m_rvld}, 32'b00010);
        pulses = 0;
        repeat (3) begin @(negedge clk); if (m_rvld) pulses++; end
        rst_n = 1'b1;
        repeat (30) begin @(negedge clk); if (m_rvld || m_busy) pulses++; end
        check_eq("rst no_rsp", pulses, 0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) phy_vec[i] = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("reset ctrl0", {26'd0, bus0.req_ready, bus0.rsp_valid, bus0.busy, mdc0, o0, oe0}, 32'b100010);
        check_eq("reset rsp0", {15'd0, bus0.rsp_ta_err, bus0.rsp_rdata}, 32'd0);
        check_eq("reset ctrl1", {26'd0, bus1.req_ready, bus1.rsp_valid, bus1.busy, mdc1, o1, oe1}, 32'b100010);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        sel = 1'b0;
        run_txn(1'b0, 2'b01, 5'h01, 5'h00, 16'h1140, 16'h0000, 1'b0, 1'b1, "c22_wr");
        run_txn(1'b0, 2'b10, 5'h03, 5'h02, 16'h0000, 16'hA5C3, 1'b0, 1'b1, "c22_rd");
        run_txn(1'b0, 2'b10, 5'h03, 5'h02, 16'h0000, 16'h0000, 1'b0, 1'b0, "no_phy");
        run_txn(1'b1, 2'b00, 5'h05, 5'h1E, 16'h8000, 16'h0000, 1'b0, 1'b1, "c45_addr");
        run_txn(1'b1, 2'b11, 5'h05, 5'h1E, 16'h0000, 16'h3C5A, 1'b1, 1'b1, "c45_rd_taerr");
        sel = 1'b1;
        run_txn(1'b1, 2'b00, 5'h05, 5'h1E, 16'h8000, 16'h0000, 1'b0, 1'b1, "noc45_addr");
        sel = 1'b0;

        back_to_back();
        reset_mid_frame();
        run_txn(1'b0, 2'b01, 5'h02, 5'h03, 16'h1234, 16'h0000, 1'b0, 1'b1, "after_rst");

        for (int r = 0; r < 10; r++) begin
            sel = (r >= 2);
            run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 5'($urandom),
                    5'($urandom), 16'($urandom), 16'($urandom),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0), "rand");
        end
        sel = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
